// File: rtl/fetch_queue.sv
// IF/ID instruction buffer: in-order FIFO of {PC, instr} with backpressure, flush and NOP on empty.
// Optional FETCH_QUEUE_BYPASS_EN: an empty queue forwards in_instr/in_PC to decode in the same cycle.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] NOP_WORD = 32'h7800_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              in_instr,
  input  logic [31:0]              in_PC,
  input  logic                     in_valid,
  output logic                     full,
  input  logic                     stall,
  input  logic                     flush,
  output logic [31:0]              IfId_out_instr,
  output logic [31:0]              IfId_out_PC,
  output logic                     IfId_out_valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          empty;
  logic          byp;
  logic          push;
  logic          wr;
  logic          pop;
  logic [63:0]   head;

  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == CW'(DEPTH));
    head  = mem_q[rptr_q];
`ifdef FETCH_QUEUE_BYPASS_EN
    byp   = empty & in_valid & ~flush;
`else
    byp   = 1'b0;
`endif
    IfId_out_valid = ~flush & (~empty | byp);
    push  = in_valid & ~full & ~flush;
    // A bypassed word that decode consumes this cycle is never stored.
    wr    = push & ~(byp & ~stall);
    pop   = ~empty & ~stall & ~flush;

    IfId_out_instr = NOP_WORD;
    IfId_out_PC    = '0;
    if (IfId_out_valid) begin
      if (byp) begin
        IfId_out_instr = in_instr;
        IfId_out_PC    = in_PC;
      end else begin
        IfId_out_instr = head[31:0];
        IfId_out_PC    = head[63:32];
      end
    end
  end

  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (flush) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      if (pop) rptr_d = rptr_q + AW'(1);
      if (wr)  wptr_d = wptr_q + AW'(1);
      unique case ({wr, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q] <= {in_PC, in_instr};
  end

  assign count = count_q;

endmodule
